// File: rtl/hpdsm_pkg.sv
// hpdsm_pkg
// Shared helpers for the high-pass delta-sigma filter chain.
// Holds the default sample width, the signed range limits for a given
// width, overflow detection and the saturate-or-wrap reduction.
// All helpers work on 64-bit signed values so any WIDTH up to 61 fits
// with headroom for the WIDTH+2 bit section difference.
package hpdsm_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int CALC_WIDTH    = 64;

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [CALC_WIDTH-1:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic logic signed [CALC_WIDTH-1:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // True when d does not fit in a signed field of the given width.
    function automatic logic is_ovf(input logic signed [CALC_WIDTH-1:0] d,
                                    input int width);
        return (d > sat_max(width)) || (d < sat_min(width));
    endfunction

    // Reduces d into the signed range of the given width, either by
    // clamping or by keeping only the low bits (sign-extended back out).
    function automatic logic signed [CALC_WIDTH-1:0] sat_or_wrap(
        input logic signed [CALC_WIDTH-1:0] d,
        input int width,
        input logic sat
    );
        logic signed [CALC_WIDTH-1:0] res;
        if (sat) begin
            if (d > sat_max(width)) begin
                res = sat_max(width);
            end else if (d < sat_min(width)) begin
                res = sat_min(width);
            end else begin
                res = d;
            end
        end else begin
            res = (d <<< (CALC_WIDTH - width)) >>> (CALC_WIDTH - width);
        end
        return res;
    endfunction

endpackage

// File: rtl/hpdsm_section.sv
// hpdsm_section
// One section of the chain: r <= (in >>> SHIFT) - r on every qualified
// sample, with the result saturated or wrapped to WIDTH bits.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear of r and the valid flag
//   in_data      signed input sample (WIDTH)
//   in_valid     in_data is qualified this cycle
//   out_data     registered section result r (WIDTH)
//   out_valid    registered copy of in_valid
//   ovf_pulse    combinational: the qualified update happening on the
//                coming edge overflows (not gated by clear)
module hpdsm_section
    import hpdsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHIFT = 1,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             ovf_pulse
);

    logic        [WIDTH-1:0]      r;
    logic                         v;
    logic signed [WIDTH:0]        ext;
    logic signed [WIDTH:0]        a;
    logic signed [WIDTH+1:0]      d;
    logic signed [CALC_WIDTH-1:0] d_wide;
    logic        [WIDTH-1:0]      r_next;

    // The extra bit before the shift keeps the shifted input exact; the
    // difference needs one more bit so it can never wrap internally.
    always_comb begin
        ext       = {in_data[WIDTH-1], in_data};
        a         = ext >>> SHIFT;
        d         = {a[WIDTH], a} - {{2{r[WIDTH-1]}}, r};
        d_wide    = CALC_WIDTH'(d);
        r_next    = WIDTH'(sat_or_wrap(d_wide, WIDTH, SAT != 0));
        ovf_pulse = in_valid && is_ovf(d_wide, WIDTH);
    end

    // Feedback state only moves on qualified samples so gaps in the
    // valid stream leave the response untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            v <= 1'b0;
        end else if (clear) begin
            r <= '0;
            v <= 1'b0;
        end else begin
            v <= in_valid;
            if (in_valid) begin
                r <= r_next;
            end
        end
    end

    assign out_data  = r;
    assign out_valid = v;

endmodule

// File: rtl/hpdsm_filter_chain.sv
// hpdsm_filter_chain
// Cascade of STAGES high-pass delta-sigma sections, one register per
// section, so a valid input appears at the output exactly STAGES cycles
// later. ovf is sticky across all sections until rst or clear.
// Parameters: WIDTH (sample width), STAGES (1..8), SHIFT (0..WIDTH-2),
//             SAT (1 = clamp, 0 = wrap).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear of all state; drops a sample given with it
//   xi, xi_valid signed input sample and its qualifier
//   yo, yo_valid registered output of the last section and its qualifier
//   ovf          sticky overflow flag
module hpdsm_filter_chain
    import hpdsm_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = 2,
    parameter int SHIFT  = 1,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] xi,
    input  logic             xi_valid,
    output logic [WIDTH-1:0] yo,
    output logic             yo_valid,
    output logic             ovf
);

    logic [STAGES:0][WIDTH-1:0] stage_data;
    logic [STAGES:0]            stage_valid;
    logic [STAGES-1:0]          stage_ovf;

    assign stage_data[0]  = xi;
    assign stage_valid[0] = xi_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_section
        hpdsm_section #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT),
            .SAT   (SAT)
        ) u_section (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .in_data   (stage_data[k]),
            .in_valid  (stage_valid[k]),
            .out_data  (stage_data[k+1]),
            .out_valid (stage_valid[k+1]),
            .ovf_pulse (stage_ovf[k])
        );
    end

    // clear wins over a simultaneous overflow because the update that
    // would have overflowed is itself discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
        end else if (|stage_ovf) begin
            ovf <= 1'b1;
        end
    end

    assign yo       = stage_data[STAGES];
    assign yo_valid = stage_valid[STAGES];

endmodule

// File: tb/tb_hpdsm_filter_chain.sv
// tb_hpdsm_filter_chain
// Directed bench for hpdsm_filter_chain. Three instances share one input
// stream: a single saturating section, the default two-section chain and
// a single wrapping section (the original base filter configuration).
module tb_hpdsm_filter_chain;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [WIDTH-1:0] xi;
    logic             xi_valid;

    logic [WIDTH-1:0] yo_s1, yo_s2, yo_w1;
    logic             yv_s1, yv_s2, yv_w1;
    logic             ovf_s1, ovf_s2, ovf_w1;

    int checks = 0;
    int errors = 0;

    hpdsm_filter_chain #(.WIDTH(WIDTH), .STAGES(1), .SHIFT(1), .SAT(1)) u_s1 (
        .clk(clk), .rst(rst), .clear(clear), .xi(xi), .xi_valid(xi_valid),
        .yo(yo_s1), .yo_valid(yv_s1), .ovf(ovf_s1)
    );

    hpdsm_filter_chain #(.WIDTH(WIDTH), .STAGES(2), .SHIFT(1), .SAT(1)) u_s2 (
        .clk(clk), .rst(rst), .clear(clear), .xi(xi), .xi_valid(xi_valid),
        .yo(yo_s2), .yo_valid(yv_s2), .ovf(ovf_s2)
    );

    hpdsm_filter_chain #(.WIDTH(WIDTH), .STAGES(1), .SHIFT(1), .SAT(0)) u_w1 (
        .clk(clk), .rst(rst), .clear(clear), .xi(xi), .xi_valid(xi_valid),
        .yo(yo_w1), .yo_valid(yv_w1), .ovf(ovf_w1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the edge
    // that consumes them, so outputs are sampled away from the edge.
    task automatic applyStimulus(input int x, input logic v, input logic c);
        xi       = WIDTH'(x);
        xi_valid = v;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    int exp_s1 [6] = '{500, 0, 500, 0, 500, 0};
    int exp_s2 [6] = '{0, 250, -250, 500, -500, 750};
    int exp_v2 [6] = '{0, 1, 1, 1, 1, 1};
    int gap_v  [4] = '{1, 0, 0, 1};
    int gap_y  [4] = '{500, 500, 500, 0};
    int sat_x  [3] = '{-32768, 32767, -32768};
    int sat_y  [3] = '{-16384, 32767, -32768};
    int wrap_y [3] = '{-16384, 32767, 16385};
    int sat_o  [3] = '{0, 0, 1};
    int valid_count;

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        xi       = '0;
        xi_valid = 1'b0;
        #1;
        checkOutput("reset_yo",    int'($signed(yo_s2)), 0);
        checkOutput("reset_valid", int'(yv_s2), 0);
        checkOutput("reset_ovf",   int'(ovf_s1), 0);
        #12;
        rst = 1'b0;

        $display("[TB] steady input 1000 through one and two sections");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1000, 1'b1, 1'b0);
            checkOutput($sformatf("s1_yo_%0d", i), int'($signed(yo_s1)), exp_s1[i]);
            checkOutput($sformatf("s1_valid_%0d", i), int'(yv_s1), 1);
            checkOutput($sformatf("w1_yo_%0d", i), int'($signed(yo_w1)), exp_s1[i]);
            checkOutput($sformatf("s2_yo_%0d", i), int'($signed(yo_s2)), exp_s2[i]);
            checkOutput($sformatf("s2_valid_%0d", i), int'(yv_s2), exp_v2[i]);
        end
        checkOutput("steady_ovf", int'(ovf_s1 | ovf_s2 | ovf_w1), 0);

        $display("[TB] clear together with a valid sample");
        applyStimulus(1000, 1'b1, 1'b1);
        checkOutput("clear_s2_yo",    int'($signed(yo_s2)), 0);
        checkOutput("clear_s2_valid", int'(yv_s2), 0);
        checkOutput("clear_s1_valid", int'(yv_s1), 0);
        checkOutput("clear_s1_ovf",   int'(ovf_s1), 0);
        applyStimulus(1000, 1'b1, 1'b0);
        checkOutput("restart_s1_yo",    int'($signed(yo_s1)), 500);
        checkOutput("restart_s2_valid", int'(yv_s2), 0);

        $display("[TB] gaps in the valid stream");
        applyStimulus(0, 1'b0, 1'b1);
        valid_count = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1000, gap_v[i][0], 1'b0);
            checkOutput($sformatf("gap_s1_yo_%0d", i), int'($signed(yo_s1)), gap_y[i]);
            checkOutput($sformatf("gap_s1_valid_%0d", i), int'(yv_s1), gap_v[i]);
            valid_count += int'(yv_s1);
        end
        checkOutput("gap_valid_count", valid_count, 2);
        checkOutput("gap_s2_held", int'($signed(yo_s2)), 250);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("gap_s2_yo",    int'($signed(yo_s2)), -250);
        checkOutput("gap_s2_valid", int'(yv_s2), 1);

        $display("[TB] saturation and wrap at full-scale inputs");
        applyStimulus(0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(sat_x[i], 1'b1, 1'b0);
            checkOutput($sformatf("sat_yo_%0d", i), int'($signed(yo_s1)), sat_y[i]);
            checkOutput($sformatf("wrap_yo_%0d", i), int'($signed(yo_w1)), wrap_y[i]);
            checkOutput($sformatf("sat_ovf_%0d", i), int'(ovf_s1), sat_o[i]);
            checkOutput($sformatf("wrap_ovf_%0d", i), int'(ovf_w1), sat_o[i]);
        end
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("ovf_sticky",      int'(ovf_s1), 1);
        checkOutput("sat_held_yo",     int'($signed(yo_s1)), -32768);

        $display("[TB] asynchronous reset between edges");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_s1_yo",    int'($signed(yo_s1)), 0);
        checkOutput("async_s2_yo",    int'($signed(yo_s2)), 0);
        checkOutput("async_ovf",      int'(ovf_s1 | ovf_w1), 0);
        checkOutput("async_s2_valid", int'(yv_s2), 0);
        #1;
        rst = 1'b0;
        applyStimulus(1000, 1'b1, 1'b0);
        checkOutput("post_rst_s1_yo",    int'($signed(yo_s1)), 500);
        checkOutput("post_rst_s2_valid", int'(yv_s2), 0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("post_rst_s2_yo",    int'($signed(yo_s2)), 250);
        checkOutput("post_rst_s2_valid2", int'(yv_s2), 1);

        $display("[TB] clear drops a set overflow flag");
        applyStimulus(0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(sat_x[i], 1'b1, 1'b0);
        end
        checkOutput("ovf_before_clear", int'(ovf_s1), 1);
        applyStimulus(1000, 1'b1, 1'b1);
        checkOutput("ovf_after_clear", int'(ovf_s1), 0);
        checkOutput("yo_after_clear",  int'($signed(yo_s1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpdsm_filter_chain.md
Name: hpdsm_filter_chain

Overview:
- Parametrised successor to the single-stage high-pass delta-sigma base filter.
- Cascades STAGES sections of the form y[n] = (x[n] >>> SHIFT) - y[n-1].
- Adds a valid-qualified datapath, one pipeline register per stage, selectable saturate or wrap arithmetic, a synchronous clear and a sticky overflow flag.
- Sits between the interpolator output and the delta-sigma modulator in the transmit chain.

Parameters:
- WIDTH, 16: sample width; two's complement in and out.
- STAGES, 2: number of cascaded sections, 1..8.
- SHIFT, 1: arithmetic right shift applied to each section input, 0..WIDTH-2.
- SAT, 1: 1 = clamp each section result to the signed WIDTH range; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous clear of all state.
- xi  in  WIDTH  input sample, signed.
- xi_valid  in  1  xi is valid this cycle.
- yo  out  WIDTH  output sample, signed; registered.
- yo_valid  out  1  yo updated this cycle.
- ovf  out  1  sticky flag: at least one section saturated or wrapped since the last rst or clear.

Behaviour:
- Reset is asynchronous and active-high. rst asserted forces every r_k to 0, every v_k to 0, and ovf to 0, so yo=0, yo_valid=0, ovf=0. Outputs stay there until the first valid sample has propagated.
- Section k (k=1..STAGES):
  - Input in_1 = xi, qualifier v_0 = xi_valid.
  - Input in_k = r_(k-1) and qualifier v_(k-1) for k>1.
  - Register r_k (WIDTH) and valid v_k.
- On each clk edge with clear=0:
  - v_k <= v_(k-1).
  - If v_(k-1)=1: r_k <= f(in_k), otherwise r_k holds.
- Section function f:
  - a = sign-extend(in_k) to WIDTH+1 bits, then arithmetic shift right by SHIFT.
  - d = a - r_k, computed in WIDTH+2 bits.
  - Overflow means d lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: result is d clamped to that range.
  - SAT=0: result is d[WIDTH-1:0].
- Feedback always uses the section's own current register value. The feedback state advances only on qualified samples, so gaps in xi_valid do not disturb the response.
- Outputs: yo = r_STAGES, yo_valid = v_STAGES.
- Latency: exactly STAGES cycles from xi_valid to yo_valid.
- Throughput: one sample per cycle; back-to-back valids are allowed.
- ovf is set in any cycle where a qualified section update overflows. It holds until rst or clear.
- clear=1 zeroes all r_k, all v_k and ovf on the next edge, and takes priority over xi_valid. A sample presented with clear is discarded.
- Asserting rst mid-stream discards all in-flight samples. There is no partial output afterwards.
- STAGES=1, SHIFT=1, SAT=0 must be bit-exact with the existing base filter when xi_valid is held high.

Decomposition:
- Shared package hpdsm_pkg holds:
  - saturate/wrap function sat_or_wrap(d, width, sat);
  - overflow-detect function;
  - constants for the signed min/max of WIDTH.
- One sub-module is natural: hpdsm_section, a single section with r, v and a per-section overflow pulse.
- hpdsm_filter_chain instantiates STAGES sections with a generate loop and ORs their overflow pulses into ovf.

Test Plan:
- STAGES=1, SHIFT=1, xi=1000 with valid every cycle -> yo sequence 500, 0, 500, 0 starting 1 cycle after the first valid; ovf=0.
- STAGES=2, same stimulus -> yo sequence 250, -250, 500, -500, 750, ... with first yo_valid 2 cycles after the first xi_valid.
- STAGES=1, SAT=1, xi alternating -32768, 32767, -32768 -> yo -16384, 32767, -32768 (clamped); ovf rises on the third update and stays high. With SAT=0 the third output is 16385.
- STAGES=1, xi=1000 with xi_valid pattern 1,0,0,1 -> yo 500 then held for two cycles with yo_valid=0, then 0; yo_valid asserts exactly twice.
- Mid-stream clear with xi_valid=1 in the same cycle -> next edge gives yo=0, yo_valid=0, ovf=0. The next valid 1000 restarts the sequence at 500.
- Assert rst asynchronously between edges while streaming -> yo, yo_valid and ovf go to 0 immediately, and no yo_valid appears until STAGES cycles after a post-reset valid.
